bin_to_bcd_seq: RTL



---
 rtl/bin_to_bcd_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one BIN_W-bit value per request,
// with start/busy/done handshake, overflow flag and a leading-zero blanking mask.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o,
  output logic [DIGITS-1:0]     blank_o
);

  localparam int unsigned CntW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic [BIN_W-1:0]      sr_q, sr_d;
  logic [4*DIGITS-1:0]   acc_q, acc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ovf_acc_q, ovf_acc_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic [DIGITS-1:0]     blank_q, blank_d;

  logic [4*DIGITS-1:0]   acc_adj;
  logic [DIGITS-1:0]     mask;
  logic                  seen_nz;

  // Add-3 correction on every digit in parallel, ahead of the shift.
  always_comb begin
    acc_adj = acc_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Digit k is blanked when it and every digit above it are zero; the ones digit never is.
  always_comb begin
    mask    = '0;
    seen_nz = 1'b0;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if (acc_q[4*k +: 4] != 4'd0) begin
        seen_nz = 1'b1;
      end
      mask[k] = ~seen_nz;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    blank_d   = blank_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          sr_d      = bin_i;
          acc_d     = '0;
          cnt_d     = CntW'(BIN_W);
          ovf_acc_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = StShift;
        end
      end
      StShift: begin
        acc_d     = {acc_adj[4*DIGITS-2:0], sr_q[BIN_W-1]};
        sr_d      = {sr_q[BIN_W-2:0], 1'b0};
        ovf_acc_d = ovf_acc_q | acc_adj[4*DIGITS-1];
        cnt_d     = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d   = acc_q;
        ovf_d   = ovf_acc_q;
        blank_d = mask;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      blank_q   <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      blank_q   <= blank_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign bcd_o   = bcd_q;
  assign ovf_o   = ovf_q;
  assign blank_o = blank_q;

endmodule
